dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single data-memory port between the core's load/store path and a secondary requester (DMA/debug loader). It sits between the core datapath (ALU result and register read data on the core side) and `data_mem`. It issues same-cycle grants so the single-cycle core is never delayed when uncontended. Contended cycles are resolved round-robin, with optional multi-cycle locks and a starvation guard; the losing core access is held off through `c_stall`, which drives the PC unit's load enable inverted.

## Interface
Parameters:
- `DATA_W`, 32, data width
- `ADDR_W`, 32, address width
- `MAX_WAIT`, 8, starvation threshold in cycles (≥1); only used with the starvation guard

Ports:
- `clk` in 1: clock, rising edge
- `areset` in 1: reset, synchronous, active-high
- `c_req`, `c_we`, `c_lock` in 1 each: core request, write enable, hold ownership
- `c_addr` in ADDR_W / `c_wdata` in DATA_W: core address and write data
- `c_gnt` out 1 / `c_rdata` out DATA_W / `c_stall` out 1: core grant, read data, stall (`c_req & ~c_gnt`)
- `d_req`, `d_we`, `d_lock` in 1 each; `d_addr` in ADDR_W; `d_wdata` in DATA_W: secondary requester
- `d_gnt` out 1 / `d_rdata` out DATA_W: secondary grant, read data
- `mem_we` out 1 / `mem_addr` out ADDR_W / `mem_wdata` out DATA_W: to `data_mem`
- `mem_rdata` in DATA_W: combinational read data from `data_mem`
- `owner` out 2: current state encoding, for debug (00 IDLE, 01 LOCK_C, 10 LOCK_D)

## Operation
- **State machine**: IDLE, LOCK_C, LOCK_D. Register `last` holds the last winner (0 = core, 1 = secondary).
- **Grants** are combinational from state, `last` and the requests. At most one grant is high in any cycle.
- **IDLE**:
  - Single requester wins.
  - Both requesting: the one not equal to `last` wins.
  - No requests: no grant.
- **LOCK_x**:
  - If `x_req`=1, x is granted regardless of the other requester (subject to the guard).
  - If `x_req`=0, the lock is released and the cycle is arbitrated as in IDLE.
- **Next state** on each edge:
  - Winner asserting `lock` goes to LOCK_winner.
  - Otherwise IDLE.
  - `last` updates to the winner whenever a grant is issued; otherwise it holds.
- **Mux**:
  - `mem_*` follow the granted port's inputs. `mem_we` = granted `we`.
  - No grant: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `x_rdata` = `mem_rdata` when `x_gnt`, else 0.
- **Reset** (`areset`=1 at an edge): state IDLE, `last`=1 (so the core wins the first contention), wait counters 0. While `areset` is high, all grants, `mem_we` and `c_stall` are forced to 0.
- **Reset mid-lock**: the lock is dropped; on the first cycle after reset the requests are arbitrated from IDLE.

## Timing
- Grant latency is 0 cycles (combinational in the request cycle).
- A write commits to `data_mem` at the edge that closes the grant cycle.
- Read data is valid in the grant cycle (combinational path `mem_rdata` → `x_rdata`).
- Requester handshake:
  - A requester must hold `req`, `addr`, `wdata` and `we` stable until the cycle in which it sees `gnt`=1.
  - The transfer completes in that cycle.
  - A requester may drop `req` in the cycle after `gnt`.
- Simultaneous lock release by the owner and request by the other side: the other side is granted in that same cycle.

## Configuration
- Macro `DMEM_ARB_STARVE_GUARD_EN`.
- **Defined**:
  - Per-port counter `wait_x`, width `$clog2(MAX_WAIT+1)`. It increments each cycle in which `x_req`=1 and `x_gnt`=0, and saturates at `MAX_WAIT`.
  - `wait_x` clears when x is granted or `x_req`=0.
  - When `wait_x`==`MAX_WAIT` and the other side holds a lock, the lock is broken. x is granted that cycle, and the next state follows the normal winner/lock rule.
- **Undefined**: counters are absent and a lock holds as long as its owner keeps `req` and `lock` high.

## Test plan
- **Uncontended core**: `c_req`=1, `c_we`=1, `c_addr`=0x10, `c_wdata`=0xDEADBEEF. Expect `c_gnt`=1 and `c_stall`=0 in the same cycle; a later read of 0x10 returns 0xDEADBEEF on `c_rdata`.
- **Round-robin**: both request for 4 cycles with no lock, starting from reset. Expect grants C, D, C, D, and `c_stall`=1 in cycles 2 and 4.
- **Lock**: D requests with `d_lock`=1 for 5 cycles while C requests continuously. Expect `d_gnt`=1 in all 5 cycles (guard off) and `owner`=10. C is granted in the cycle D drops `req`.
- **Starvation guard** (macro on, `MAX_WAIT`=3): D locks indefinitely while C requests. Expect `c_gnt`=1 in the 4th cycle of C waiting, then `wait_c`=0.
- **Reset mid-lock**: from LOCK_D, assert `areset` for 1 cycle with both requesting. Expect all grants 0 during reset; the next cycle C wins (`last`=1) and `owner`=00.
- **Idle bus**: no requests. Expect `mem_we`=0, `mem_addr`=0, `c_rdata`=`d_rdata`=0, with `mem_rdata` driven to 0x12345678.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data_mem port between the core load/store
// path (c_*) and a secondary requester (d_*, DMA/debug loader).
//
// Ports:
//   clk, areset                  clock, synchronous active-high reset
//   c_req/c_we/c_lock            core request, write enable, hold ownership
//   c_addr/c_wdata               core address and write data
//   c_gnt/c_rdata/c_stall        core grant, read data, stall (c_req & ~c_gnt)
//   d_req/d_we/d_lock            secondary request, write enable, hold ownership
//   d_addr/d_wdata               secondary address and write data
//   d_gnt/d_rdata                secondary grant, read data
//   mem_we/mem_addr/mem_wdata    to data_mem
//   mem_rdata                    combinational read data from data_mem
//   owner                        state for debug (00 IDLE, 01 LOCK_C, 10 LOCK_D)
//
// Grants are combinational, so an uncontended access completes in the
// request cycle. Contention is round-robin on the last winner; a winner
// asserting lock keeps the port while it keeps requesting.
//
// Optional macro DMEM_ARB_STARVE_GUARD_EN adds per-port wait counters that
// break the other side's lock once a requester has waited MAX_WAIT cycles.
module dmem_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic              c_lock,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_LOCK_C = 2'b01;
    localparam logic [1:0] ST_LOCK_D = 2'b10;

    logic [1:0] state_q, state_d;
    logic       last_q, last_d;
    logic       gnt_c, gnt_d;
    logic       arb_c, arb_d;
    logic       brk_c, brk_d;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

    logic [WW-1:0] wait_c_q, wait_c_d;
    logic [WW-1:0] wait_d_q, wait_d_d;

    // A starved requester overrides the other side's lock.
    assign brk_c = c_req && (wait_c_q == WMAX) && (state_q == ST_LOCK_D) && d_req;
    assign brk_d = d_req && (wait_d_q == WMAX) && (state_q == ST_LOCK_C) && c_req;

    always_comb begin
        wait_c_d = '0;
        wait_d_d = '0;
        if (c_req && !gnt_c)
            wait_c_d = (wait_c_q == WMAX) ? wait_c_q : wait_c_q + 1'b1;
        if (d_req && !gnt_d)
            wait_d_d = (wait_d_q == WMAX) ? wait_d_q : wait_d_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            wait_c_q <= '0;
            wait_d_q <= '0;
        end else begin
            wait_c_q <= wait_c_d;
            wait_d_q <= wait_d_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (MAX_WAIT > 0);
    assign brk_c = 1'b0;
    assign brk_d = 1'b0;
`endif

    // Open arbitration: last_q = 1 means the secondary won last, so core wins.
    assign arb_c = c_req && (!d_req || last_q);
    assign arb_d = d_req && (!c_req || !last_q);

    always_comb begin
        gnt_c = 1'b0;
        gnt_d = 1'b0;
        case (state_q)
            ST_LOCK_C: begin
                if (brk_d)      gnt_d = 1'b1;
                else if (c_req) gnt_c = 1'b1;
                else begin
                    gnt_c = arb_c;
                    gnt_d = arb_d;
                end
            end
            ST_LOCK_D: begin
                if (brk_c)      gnt_c = 1'b1;
                else if (d_req) gnt_d = 1'b1;
                else begin
                    gnt_c = arb_c;
                    gnt_d = arb_d;
                end
            end
            default: begin
                gnt_c = arb_c;
                gnt_d = arb_d;
            end
        endcase
    end

    always_comb begin
        state_d = ST_IDLE;
        last_d  = last_q;
        if (gnt_c) begin
            last_d = 1'b0;
            if (c_lock) state_d = ST_LOCK_C;
        end else if (gnt_d) begin
            last_d = 1'b1;
            if (d_lock) state_d = ST_LOCK_D;
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Outputs are silenced while reset is held.
    assign c_gnt   = gnt_c && !areset;
    assign d_gnt   = gnt_d && !areset;
    assign c_stall = c_req && !c_gnt && !areset;
    assign owner   = state_q;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (c_gnt) begin
            mem_we    = c_we;
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
        end else if (d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    assign c_rdata = c_gnt ? mem_rdata : '0;
    assign d_rdata = d_gnt ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: per-cycle vector table plus hand sequences
// for lock hold/release and (with the guard macro) starvation breaking.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        areset;
    logic        c_req, c_we, c_lock;
    logic [31:0] c_addr, c_wdata;
    logic        c_gnt, c_stall;
    logic [31:0] c_rdata;
    logic        d_req, d_we, d_lock;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt;
    logic [31:0] d_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  owner;

    logic [31:0] mem [0:63];
    logic        ovr;
    logic [31:0] ovr_val;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .areset(areset),
        .c_req(c_req), .c_we(c_we), .c_lock(c_lock),
        .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rdata(c_rdata), .c_stall(c_stall),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    // Simple data_mem model: combinational read, write at the clock edge.
    assign mem_rdata = ovr ? ovr_val : mem[mem_addr[7:2]];
    always @(posedge clk)
        if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

    typedef struct {
        logic        rst;
        logic        cr, cw, cl;
        logic [31:0] ca, cd;
        logic        dr, dw, dl;
        logic [31:0] da, dd;
        logic        ov;
        logic [31:0] ovv;
        logic        e_cg, e_dg, e_st, e_we;
        logic [31:0] e_ad, e_wd, e_crd, e_drd;
        logic [1:0]  e_own;
    } vec_t;

    vec_t vt [0:19];

    function automatic vec_t mk(
        input logic rst, input logic cr, input logic cw, input logic cl,
        input logic [31:0] ca, input logic [31:0] cd,
        input logic dr, input logic dw, input logic dl,
        input logic [31:0] da, input logic [31:0] dd,
        input logic ov, input logic [31:0] ovv,
        input logic e_cg, input logic e_dg, input logic e_st, input logic e_we,
        input logic [31:0] e_ad, input logic [31:0] e_wd,
        input logic [31:0] e_crd, input logic [31:0] e_drd,
        input logic [1:0] e_own);
        vec_t v;
        v.rst = rst; v.cr = cr; v.cw = cw; v.cl = cl; v.ca = ca; v.cd = cd;
        v.dr = dr; v.dw = dw; v.dl = dl; v.da = da; v.dd = dd;
        v.ov = ov; v.ovv = ovv;
        v.e_cg = e_cg; v.e_dg = e_dg; v.e_st = e_st; v.e_we = e_we;
        v.e_ad = e_ad; v.e_wd = e_wd; v.e_crd = e_crd; v.e_drd = e_drd;
        v.e_own = e_own;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic cr, input logic cw,
                         input logic cl, input logic [31:0] ca,
                         input logic [31:0] cd, input logic dr,
                         input logic dw, input logic dl,
                         input logic [31:0] da, input logic [31:0] dd);
        areset = rst; c_req = cr; c_we = cw; c_lock = cl;
        c_addr = ca; c_wdata = cd;
        d_req = dr; d_we = dw; d_lock = dl; d_addr = da; d_wdata = dd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        ovr = 1'b0;
        ovr_val = '0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        //          rst cr cw cl ca     cd            dr dw dl da     dd            ov ovv
        //          cg dg st we addr    wdata         c_rdata       d_rdata  own
        vt[0]  = mk(1, 1, 0, 0, 32'h20, 0,            1, 0, 0, 32'h30, 0,            0, 0,
                    0, 0, 0, 0, 0,      0,            0,            0,       2'b00);
        vt[1]  = mk(0, 0, 0, 0, 0,      0,            0, 0, 0, 0,      0,            1, 32'h12345678,
                    0, 0, 0, 0, 0,      0,            0,            0,       2'b00);
        vt[2]  = mk(0, 1, 1, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0,      0,            0, 0,
                    1, 0, 0, 1, 32'h10, 32'hDEADBEEF, 0,            0,       2'b00);
        vt[3]  = mk(0, 1, 0, 0, 32'h10, 0,            0, 0, 0, 0,      0,            0, 0,
                    1, 0, 0, 0, 32'h10, 0,            32'hDEADBEEF, 0,       2'b00);
        vt[4]  = mk(1, 0, 0, 0, 0,      0,            0, 0, 0, 0,      0,            0, 0,
                    0, 0, 0, 0, 0,      0,            0,            0,       2'b00);
        vt[5]  = mk(0, 1, 0, 0, 32'h20, 0,            1, 0, 0, 32'h30, 0,            0, 0,
                    1, 0, 0, 0, 32'h20, 0,            0,            0,       2'b00);
        vt[6]  = mk(0, 1, 0, 0, 32'h20, 0,            1, 0, 0, 32'h30, 0,            0, 0,
                    0, 1, 1, 0, 32'h30, 0,            0,            0,       2'b00);
        vt[7]  = mk(0, 1, 0, 0, 32'h20, 0,            1, 0, 0, 32'h30, 0,            0, 0,
                    1, 0, 0, 0, 32'h20, 0,            0,            0,       2'b00);
        vt[8]  = mk(0, 1, 0, 0, 32'h20, 0,            1, 0, 0, 32'h30, 0,            0, 0,
                    0, 1, 1, 0, 32'h30, 0,            0,            0,       2'b00);
        vt[9]  = mk(0, 1, 0, 0, 32'h10, 0,            0, 0, 0, 0,      0,            0, 0,
                    1, 0, 0, 0, 32'h10, 0,            32'hDEADBEEF, 0,       2'b00);
        vt[10] = mk(0, 1, 0, 0, 32'h40, 0,            1, 1, 1, 32'h40, 32'hCAFEF00D, 0, 0,
                    0, 1, 1, 1, 32'h40, 32'hCAFEF00D, 0,            0,       2'b00);
        for (int i = 11; i < 15; i++)
            vt[i] = mk(0, 1, 0, 0, 32'h40, 0,         1, 1, 1, 32'h40, 32'hCAFEF00D, 0, 0,
                    0, 1, 1, 1, 32'h40, 32'hCAFEF00D, 0,            32'hCAFEF00D, 2'b10);
        vt[15] = mk(0, 1, 0, 0, 32'h40, 0,            0, 0, 0, 0,      0,            0, 0,
                    1, 0, 0, 0, 32'h40, 0,            32'hCAFEF00D, 0,       2'b10);
        vt[16] = mk(0, 1, 0, 0, 32'h20, 0,            1, 0, 1, 32'h30, 0,            0, 0,
                    0, 1, 1, 0, 32'h30, 0,            0,            0,       2'b00);
        vt[17] = mk(0, 1, 0, 0, 32'h20, 0,            1, 0, 1, 32'h30, 0,            0, 0,
                    0, 1, 1, 0, 32'h30, 0,            0,            0,       2'b10);
        vt[18] = mk(1, 1, 0, 0, 32'h20, 0,            1, 0, 1, 32'h30, 0,            0, 0,
                    0, 0, 0, 0, 0,      0,            0,            0,       2'b10);
        vt[19] = mk(0, 1, 0, 0, 32'h20, 0,            1, 0, 1, 32'h30, 0,            0, 0,
                    1, 0, 0, 0, 32'h20, 0,            0,            0,       2'b00);

        for (int i = 0; i < 20; i++) begin
            drive(vt[i].rst, vt[i].cr, vt[i].cw, vt[i].cl, vt[i].ca, vt[i].cd,
                  vt[i].dr, vt[i].dw, vt[i].dl, vt[i].da, vt[i].dd);
            ovr = vt[i].ov;
            ovr_val = vt[i].ovv;
            @(negedge clk);
            chk("c_gnt",     i, {31'b0, c_gnt},   {31'b0, vt[i].e_cg});
            chk("d_gnt",     i, {31'b0, d_gnt},   {31'b0, vt[i].e_dg});
            chk("c_stall",   i, {31'b0, c_stall}, {31'b0, vt[i].e_st});
            chk("mem_we",    i, {31'b0, mem_we},  {31'b0, vt[i].e_we});
            chk("mem_addr",  i, mem_addr,         vt[i].e_ad);
            chk("mem_wdata", i, mem_wdata,        vt[i].e_wd);
            chk("c_rdata",   i, c_rdata,          vt[i].e_crd);
            chk("d_rdata",   i, d_rdata,          vt[i].e_drd);
            chk("owner",     i, {30'b0, owner},   {30'b0, vt[i].e_own});
            step();
        end
        ovr = 1'b0;

        // Core takes a lock uncontended, holds it against D, then releases
        // by dropping req: D must be granted in that same cycle.
        drive(0, 1, 0, 1, 32'h10, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lc_gnt", 0, {31'b0, c_gnt}, 32'd1);
        step();
        for (int i = 1; i < 4; i++) begin
            drive(0, 1, 0, 1, 32'h10, 0, 1, 0, 0, 32'h30, 0);
            @(negedge clk);
            chk("lc_cgnt",  i, {31'b0, c_gnt}, 32'd1);
            chk("lc_dgnt",  i, {31'b0, d_gnt}, 32'd0);
            chk("lc_owner", i, {30'b0, owner}, 32'd1);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h30, 0);
        @(negedge clk);
        chk("lc_rel_dgnt", 4, {31'b0, d_gnt}, 32'd1);
        chk("lc_rel_addr", 4, mem_addr, 32'h30);
        step();

`ifdef DMEM_ARB_STARVE_GUARD_EN
        // D takes a lock, then holds it while C waits; with MAX_WAIT=8 the
        // guard hands the port to C on its 9th waiting cycle.
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h30, 0);
        step();
        for (int i = 1; i <= 9; i++) begin
            drive(0, 1, 0, 0, 32'h20, 0, 1, 0, 1, 32'h30, 0);
            @(negedge clk);
            chk("sg_cgnt", i, {31'b0, c_gnt}, (i == 9) ? 32'd1 : 32'd0);
            chk("sg_dgnt", i, {31'b0, d_gnt}, (i == 9) ? 32'd0 : 32'd1);
            step();
        end
        chk("sg_wait_c", 10, 32'(dut.wait_c_q), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
